// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared machine-mode CSR types for the v1.12 privilege block.
// Holds the CSR address map, register layouts, WARL write masks and WARL helpers.
package machine_mode_types_1_12_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS       = 12'h300,
    CSR_MISA          = 12'h301,
    CSR_MIE           = 12'h304,
    CSR_MTVEC         = 12'h305,
    CSR_MCOUNTINHIBIT = 12'h320,
    CSR_MSCRATCH      = 12'h340,
    CSR_MEPC          = 12'h341,
    CSR_MCAUSE        = 12'h342,
    CSR_MTVAL         = 12'h343,
    CSR_MIP           = 12'h344,
    CSR_MCYCLE        = 12'hB00,
    CSR_MINSTRET      = 12'hB02,
    CSR_MCYCLEH       = 12'hB80,
    CSR_MINSTRETH     = 12'hB82,
    CSR_MVENDORID     = 12'hF11,
    CSR_MARCHID       = 12'hF12,
    CSR_MIMPID        = 12'hF13,
    CSR_MHARTID       = 12'hF14
  } csr_addr_e;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'd0,
    MTVEC_VECTORED = 2'd1,
    MTVEC_RSVD2    = 2'd2,
    MTVEC_RSVD3    = 2'd3
  } mtvec_mode_e;

  typedef struct packed {
    logic [18:0] rsvd_hi;
    logic [1:0]  mpp;
    logic [2:0]  rsvd_mid;
    logic        mpie;
    logic [2:0]  rsvd_lo;
    logic        mie;
    logic [2:0]  rsvd_0;
  } mstatus_t;

  typedef struct packed {
    logic [19:0] rsvd_hi;
    logic        meie;
    logic [2:0]  rsvd_mid;
    logic        mtie;
    logic [2:0]  rsvd_lo;
    logic        msie;
    logic [2:0]  rsvd_0;
  } mie_t;

  typedef struct packed {
    logic [19:0] rsvd_hi;
    logic        meip;
    logic [2:0]  rsvd_mid;
    logic        mtip;
    logic [2:0]  rsvd_lo;
    logic        msip;
    logic [2:0]  rsvd_0;
  } mip_t;

  typedef struct packed {
    logic        interrupt;
    logic [30:0] code;
  } mcause_t;

  typedef struct packed {
    logic [29:0] base;
    mtvec_mode_e mode;
  } mtvec_t;

  localparam logic [31:0] MSTATUS_WMASK       = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_RESET       = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK           = 32'h0000_0888;
  localparam logic [31:0] MEPC_WMASK          = 32'hFFFF_FFFC;
  localparam logic [31:0] MCOUNTINHIBIT_WMASK = 32'h0000_0005;

  function automatic logic [31:0] warl_mstatus(input logic [31:0] val);
    mstatus_t s;
    s     = mstatus_t'(val & MSTATUS_WMASK);
    s.mpp = 2'b11;
    return s;
  endfunction

  // Reserved MODE encodings leave the whole register untouched.
  function automatic logic [31:0] warl_mtvec(input logic [31:0] old, input logic [31:0] val);
    mtvec_t t;
    t = mtvec_t'(val);
    if ((t.mode == MTVEC_RSVD2) || (t.mode == MTVEC_RSVD3)) begin
      return old;
    end else begin
      return val;
    end
  endfunction

  function automatic logic [31:0] warl_masked(input logic [31:0] old, input logic [31:0] val,
                                              input logic [31:0] wmask);
    return (old & ~wmask) | (val & wmask);
  endfunction

endpackage

// File: rtl/priv_1_12_csr_file_if.sv
// CSR access and handler-update bundle between pipeline/handler (master) and CSR file (slave).
interface priv_1_12_csr_file_if;
  logic [1:0]  curr_priv;
  logic [11:0] csr_addr;
  logic        csr_write;
  logic        csr_set;
  logic        csr_clear;
  logic [31:0] new_csr_val;
  logic        valid_write;
  logic        inst_ret;
  logic        inject_mstatus;
  logic        inject_mie;
  logic        inject_mip;
  logic        inject_mcause;
  logic        inject_mepc;
  logic        inject_mtval;
  logic [31:0] next_mstatus;
  logic [31:0] next_mie;
  logic [31:0] next_mip;
  logic [31:0] next_mcause;
  logic [31:0] next_mepc;
  logic [31:0] next_mtval;
  logic [31:0] old_csr_val;
  logic        invalid_csr;
  logic [31:0] curr_mstatus;
  logic [31:0] curr_mie;
  logic [31:0] curr_mip;
  logic [31:0] curr_mcause;
  logic [31:0] curr_mepc;
  logic [31:0] curr_mtvec;
  logic [31:0] curr_mtval;

  modport master (
    output curr_priv, csr_addr, csr_write, csr_set, csr_clear, new_csr_val, valid_write, inst_ret,
    output inject_mstatus, inject_mie, inject_mip, inject_mcause, inject_mepc, inject_mtval,
    output next_mstatus, next_mie, next_mip, next_mcause, next_mepc, next_mtval,
    input  old_csr_val, invalid_csr,
    input  curr_mstatus, curr_mie, curr_mip, curr_mcause, curr_mepc, curr_mtvec, curr_mtval
  );

  modport slave (
    input  curr_priv, csr_addr, csr_write, csr_set, csr_clear, new_csr_val, valid_write, inst_ret,
    input  inject_mstatus, inject_mie, inject_mip, inject_mcause, inject_mepc, inject_mtval,
    input  next_mstatus, next_mie, next_mip, next_mcause, next_mepc, next_mtval,
    output old_csr_val, invalid_csr,
    output curr_mstatus, curr_mie, curr_mip, curr_mcause, curr_mepc, curr_mtvec, curr_mtval
  );
endinterface

// File: rtl/priv_1_12_counter64.sv
// 64-bit performance counter with per-half software load and inhibit.
// A load of one half holds the other half and suppresses that cycle's increment.
module priv_1_12_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        inhibit,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  output logic [63:0] count
);

  logic [63:0] count_r;
  logic [63:0] count_next_s;

  // Next count: software load wins over increment
  always_comb begin
    count_next_s = count_r;
    if (wr_lo) begin
      count_next_s = {count_r[63:32], wr_data};
    end else if (wr_hi) begin
      count_next_s = {wr_data, count_r[31:0]};
    end else if (inc && !inhibit) begin
      count_next_s = count_r + 64'd1;
    end else begin
      count_next_s = count_r;
    end
  end

  // Counter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 64'd0;
    end else begin
      count_r <= count_next_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/priv_1_12_csr_file_checker.sv
// Protocol and invariant checks for the machine-mode CSR file.
module priv_1_12_csr_file_checker (
  input logic        clk,
  input logic        rst_n,
  input logic        csr_write,
  input logic        csr_set,
  input logic        csr_clear,
  input logic [31:0] curr_mstatus,
  input logic [31:0] curr_mepc
);

  a_ops_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({csr_write, csr_set, csr_clear}))
    else $error("more than one CSR op asserted in the same cycle");

  a_mpp_fixed: assert property (@(posedge clk) disable iff (!rst_n)
    curr_mstatus[12:11] == 2'b11)
    else $error("mstatus.MPP left machine mode");

  a_mepc_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    curr_mepc[1:0] == 2'b00)
    else $error("mepc low bits not zero");

endmodule

// File: rtl/priv_1_12_csr_file.sv
// Machine-mode CSR file: combinational read/legality path, committed software RMW,
// handler injection with priority over software, and the mcycle/minstret counters.
module priv_1_12_csr_file
  import machine_mode_types_1_12_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0200,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MIP_WMASK   = 32'h0000_0000
) (
  input logic                  CLK,
  input logic                  nRST,
  priv_1_12_csr_file_if.slave  bus
);

  logic [31:0] mstatus_r, mie_r, mip_r, mtvec_r, mepc_r, mcause_r, mtval_r;
  logic [31:0] mscratch_r, mcountinhibit_r;
  logic [63:0] mcycle_s, minstret_s;

  logic [31:0] old_val_s;
  logic [31:0] op_val_s;
  logic        implemented_s;
  logic        any_op_s;
  logic        invalid_s;
  logic        commit_s;

  // Read mux; anything not listed reads zero and is flagged unimplemented
  always_comb begin
    old_val_s     = 32'd0;
    implemented_s = 1'b1;
    case (bus.csr_addr)
      CSR_MSTATUS:       old_val_s = mstatus_r;
      CSR_MISA:          old_val_s = MISA_VALUE;
      CSR_MIE:           old_val_s = mie_r;
      CSR_MTVEC:         old_val_s = mtvec_r;
      CSR_MCOUNTINHIBIT: old_val_s = mcountinhibit_r;
      CSR_MSCRATCH:      old_val_s = mscratch_r;
      CSR_MEPC:          old_val_s = mepc_r;
      CSR_MCAUSE:        old_val_s = mcause_r;
      CSR_MTVAL:         old_val_s = mtval_r;
      CSR_MIP:           old_val_s = mip_r;
      CSR_MCYCLE:        old_val_s = mcycle_s[31:0];
      CSR_MINSTRET:      old_val_s = minstret_s[31:0];
      CSR_MCYCLEH:       old_val_s = mcycle_s[63:32];
      CSR_MINSTRETH:     old_val_s = minstret_s[63:32];
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MIMPID:        old_val_s = 32'd0;
      CSR_MHARTID:       old_val_s = HART_ID;
      default: begin
        old_val_s     = 32'd0;
        implemented_s = 1'b0;
      end
    endcase
  end

  // Operand for the read-modify-write
  always_comb begin
    op_val_s = old_val_s;
    if (bus.csr_write) begin
      op_val_s = bus.new_csr_val;
    end else if (bus.csr_set) begin
      op_val_s = old_val_s | bus.new_csr_val;
    end else if (bus.csr_clear) begin
      op_val_s = old_val_s & ~bus.new_csr_val;
    end else begin
      op_val_s = old_val_s;
    end
  end

  // Every op is write-class, so a set/clear with a zero operand still faults on read-only CSRs.
  assign any_op_s  = bus.csr_write | bus.csr_set | bus.csr_clear;
  assign invalid_s = any_op_s & (~implemented_s
                                 | (bus.curr_priv < bus.csr_addr[9:8])
                                 | (bus.csr_addr[11:10] == 2'b11));
  assign commit_s  = bus.valid_write & any_op_s & ~invalid_s;

  function automatic logic wr_sel(input logic commit, input logic [11:0] addr, input csr_addr_e target);
    return commit && (addr == target);
  endfunction

  // Interrupt-enable/status CSRs; handler injection outranks software
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mstatus_r <= MSTATUS_RESET;
      mie_r     <= 32'd0;
      mip_r     <= 32'd0;
    end else begin
      if (bus.inject_mstatus) begin
        mstatus_r <= warl_mstatus(bus.next_mstatus);
      end else if (wr_sel(commit_s, bus.csr_addr, CSR_MSTATUS)) begin
        mstatus_r <= warl_mstatus(op_val_s);
      end
      if (bus.inject_mie) begin
        mie_r <= bus.next_mie & MIE_WMASK;
      end else if (wr_sel(commit_s, bus.csr_addr, CSR_MIE)) begin
        mie_r <= op_val_s & MIE_WMASK;
      end
      if (bus.inject_mip) begin
        mip_r <= bus.next_mip;
      end else if (wr_sel(commit_s, bus.csr_addr, CSR_MIP)) begin
        mip_r <= warl_masked(mip_r, op_val_s, MIP_WMASK);
      end
    end
  end

  // Trap-context CSRs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mtvec_r  <= MTVEC_RESET;
      mepc_r   <= 32'd0;
      mcause_r <= 32'd0;
      mtval_r  <= 32'd0;
    end else begin
      if (wr_sel(commit_s, bus.csr_addr, CSR_MTVEC)) begin
        mtvec_r <= warl_mtvec(mtvec_r, op_val_s);
      end
      if (bus.inject_mepc) begin
        mepc_r <= bus.next_mepc & MEPC_WMASK;
      end else if (wr_sel(commit_s, bus.csr_addr, CSR_MEPC)) begin
        mepc_r <= op_val_s & MEPC_WMASK;
      end
      if (bus.inject_mcause) begin
        mcause_r <= bus.next_mcause;
      end else if (wr_sel(commit_s, bus.csr_addr, CSR_MCAUSE)) begin
        mcause_r <= op_val_s;
      end
      if (bus.inject_mtval) begin
        mtval_r <= bus.next_mtval;
      end else if (wr_sel(commit_s, bus.csr_addr, CSR_MTVAL)) begin
        mtval_r <= op_val_s;
      end
    end
  end

  // Software-only scratch and counter-inhibit CSRs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mscratch_r      <= 32'd0;
      mcountinhibit_r <= 32'd0;
    end else begin
      if (wr_sel(commit_s, bus.csr_addr, CSR_MSCRATCH)) begin
        mscratch_r <= op_val_s;
      end
      if (wr_sel(commit_s, bus.csr_addr, CSR_MCOUNTINHIBIT)) begin
        mcountinhibit_r <= op_val_s & MCOUNTINHIBIT_WMASK;
      end
    end
  end

  priv_1_12_counter64 u_mcycle (
    .clk     (CLK),
    .rst_n   (nRST),
    .inc     (1'b1),
    .inhibit (mcountinhibit_r[0]),
    .wr_lo   (wr_sel(commit_s, bus.csr_addr, CSR_MCYCLE)),
    .wr_hi   (wr_sel(commit_s, bus.csr_addr, CSR_MCYCLEH)),
    .wr_data (op_val_s),
    .count   (mcycle_s)
  );

  priv_1_12_counter64 u_minstret (
    .clk     (CLK),
    .rst_n   (nRST),
    .inc     (bus.inst_ret),
    .inhibit (mcountinhibit_r[2]),
    .wr_lo   (wr_sel(commit_s, bus.csr_addr, CSR_MINSTRET)),
    .wr_hi   (wr_sel(commit_s, bus.csr_addr, CSR_MINSTRETH)),
    .wr_data (op_val_s),
    .count   (minstret_s)
  );

  priv_1_12_csr_file_checker u_checker (
    .clk          (CLK),
    .rst_n        (nRST),
    .csr_write    (bus.csr_write),
    .csr_set      (bus.csr_set),
    .csr_clear    (bus.csr_clear),
    .curr_mstatus (mstatus_r),
    .curr_mepc    (mepc_r)
  );

  assign bus.old_csr_val  = old_val_s;
  assign bus.invalid_csr  = invalid_s;
  assign bus.curr_mstatus = mstatus_r;
  assign bus.curr_mie     = mie_r;
  assign bus.curr_mip     = mip_r;
  assign bus.curr_mcause  = mcause_r;
  assign bus.curr_mepc    = mepc_r;
  assign bus.curr_mtvec   = mtvec_r;
  assign bus.curr_mtval   = mtval_r;

endmodule

// File: tb/tb_priv_1_12_csr_file.sv
// Directed-vector bench for the machine-mode CSR file; expectations are hand-computed.
module tb_priv_1_12_csr_file;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_WR   = 2'd1;
  localparam logic [1:0] OP_SET  = 2'd2;
  localparam logic [1:0] OP_CLR  = 2'd3;

  logic CLK;
  logic nRST;
  int   vec_cnt;
  int   miscompare_cnt;

  priv_1_12_csr_file_if bus ();

  priv_1_12_csr_file dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.csr_write      = 1'b0;
    bus.csr_set        = 1'b0;
    bus.csr_clear      = 1'b0;
    bus.valid_write    = 1'b0;
    bus.new_csr_val    = 32'd0;
    bus.inject_mstatus = 1'b0;
    bus.inject_mie     = 1'b0;
    bus.inject_mip     = 1'b0;
    bus.inject_mcause  = 1'b0;
    bus.inject_mepc    = 1'b0;
    bus.inject_mtval   = 1'b0;
  endtask

  // Apply one op, check the legality flag before the edge, commit on the edge.
  task automatic csr_op(input string tag, input logic [11:0] a, input logic [1:0] kind,
                        input logic [31:0] v, input logic vw, input logic exp_inv);
    bus.csr_addr    = a;
    bus.csr_write   = (kind == OP_WR);
    bus.csr_set     = (kind == OP_SET);
    bus.csr_clear   = (kind == OP_CLR);
    bus.new_csr_val = v;
    bus.valid_write = vw;
    #1;
    check_vec({tag, "_inv"}, {31'd0, bus.invalid_csr}, {31'd0, exp_inv});
    tick();
    idle();
  endtask

  task automatic check_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_addr = a;
    #1;
    check_vec(tag, bus.old_csr_val, exp);
  endtask

  initial begin
    vec_cnt        = 0;
    miscompare_cnt = 0;
    idle();
    bus.curr_priv    = 2'b11;
    bus.csr_addr     = 12'h300;
    bus.inst_ret     = 1'b0;
    bus.next_mstatus = 32'd0;
    bus.next_mie     = 32'd0;
    bus.next_mip     = 32'd0;
    bus.next_mcause  = 32'd0;
    bus.next_mepc    = 32'd0;
    bus.next_mtval   = 32'd0;
    nRST = 1'b1;
    #1 nRST = 1'b0;
    #1;
    check_vec("rst_mtvec", bus.curr_mtvec, 32'h0000_0200);
    check_vec("rst_mstatus", bus.curr_mstatus, 32'h0000_1800);
    repeat (2) @(posedge CLK);
    @(negedge CLK) nRST = 1'b1;
    tick();

    // reset values through the read path
    check_rd("rd_mtvec", 12'h305, 32'h0000_0200);
    check_rd("rd_mstatus", 12'h300, 32'h0000_1800);
    check_rd("rd_misa", 12'h301, 32'h4000_0100);
    check_rd("rd_mhartid", 12'hF14, 32'd0);
    check_vec("curr_mie0", bus.curr_mie, 32'd0);
    check_vec("curr_mepc0", bus.curr_mepc, 32'd0);
    check_vec("curr_mcause0", bus.curr_mcause, 32'd0);
    tick();

    // mstatus set/clear and WARL
    csr_op("set_mst", 12'h300, OP_SET, 32'h0000_0088, 1'b1, 1'b0);
    check_vec("mst_set", bus.curr_mstatus, 32'h0000_1888);
    csr_op("clr_nocommit", 12'h300, OP_CLR, 32'h0000_0088, 1'b0, 1'b0);
    check_vec("mst_nocommit", bus.curr_mstatus, 32'h0000_1888);
    csr_op("wr_mst_all", 12'h300, OP_WR, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check_vec("mst_warl", bus.curr_mstatus, 32'h0000_1888);
    csr_op("clr_mie", 12'h300, OP_CLR, 32'h0000_0008, 1'b1, 1'b0);
    check_vec("mst_clr", bus.curr_mstatus, 32'h0000_1880);

    // injection priority and mepc alignment
    bus.inject_mepc = 1'b1;
    bus.next_mepc   = 32'h0000_4000;
    csr_op("mepc_race", 12'h341, OP_WR, 32'h1234_5677, 1'b1, 1'b0);
    check_vec("mepc_inject", bus.curr_mepc, 32'h0000_4000);
    csr_op("mepc_sw", 12'h341, OP_WR, 32'h1234_5677, 1'b1, 1'b0);
    check_vec("mepc_align", bus.curr_mepc, 32'h1234_5674);
    bus.inject_mcause = 1'b1;
    bus.next_mcause   = 32'h8000_000B;
    csr_op("mscratch_wr", 12'h340, OP_WR, 32'hA5A5_5A5A, 1'b1, 1'b0);
    check_vec("mcause_inject", bus.curr_mcause, 32'h8000_000B);
    check_rd("rd_mscratch", 12'h340, 32'hA5A5_5A5A);

    // mtvec mode WARL, mie/mip masks, handler inject of mip/mstatus
    csr_op("mtvec_mode2", 12'h305, OP_WR, 32'h0000_1002, 1'b1, 1'b0);
    check_vec("mtvec_hold", bus.curr_mtvec, 32'h0000_0200);
    csr_op("mtvec_vec", 12'h305, OP_WR, 32'h0000_1001, 1'b1, 1'b0);
    check_vec("mtvec_load", bus.curr_mtvec, 32'h0000_1001);
    csr_op("mie_all", 12'h304, OP_WR, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check_vec("mie_mask", bus.curr_mie, 32'h0000_0888);
    csr_op("mip_all", 12'h344, OP_WR, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check_vec("mip_ro", bus.curr_mip, 32'd0);
    bus.inject_mip     = 1'b1;
    bus.next_mip       = 32'h0000_FFFF;
    bus.inject_mstatus = 1'b1;
    bus.next_mstatus   = 32'hFFFF_FFFF;
    csr_op("inj_only", 12'h300, OP_NONE, 32'd0, 1'b0, 1'b0);
    check_vec("mip_inject", bus.curr_mip, 32'h0000_FFFF);
    check_vec("mst_inject", bus.curr_mstatus, 32'h0000_1888);

    // illegal accesses
    bus.curr_priv = 2'b00;
    csr_op("u_wr_mst", 12'h300, OP_WR, 32'd0, 1'b1, 1'b1);
    check_vec("u_mst_hold", bus.curr_mstatus, 32'h0000_1888);
    bus.curr_priv = 2'b01;
    csr_op("s_wr_mscr", 12'h340, OP_WR, 32'd0, 1'b1, 1'b1);
    check_rd("mscr_hold", 12'h340, 32'hA5A5_5A5A);
    bus.curr_priv = 2'b11;
    csr_op("wr_hartid", 12'hF14, OP_WR, 32'd1, 1'b1, 1'b1);
    csr_op("set0_hartid", 12'hF14, OP_SET, 32'd0, 1'b1, 1'b1);
    csr_op("rd_hartid_noop", 12'hF14, OP_NONE, 32'd0, 1'b0, 1'b0);
    csr_op("set_unimpl", 12'h7C0, OP_SET, 32'd1, 1'b1, 1'b1);
    check_rd("rd_unimpl", 12'h7C0, 32'd0);

    // mcycle low-half wrap carries into the high half
    csr_op("mcyc_lo", 12'hB00, OP_WR, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check_rd("mcyc_lo_ld", 12'hB00, 32'hFFFF_FFFF);
    check_rd("mcyc_hi_0", 12'hB80, 32'd0);
    tick();
    check_rd("mcyc_lo_wrap", 12'hB00, 32'd0);
    check_rd("mcyc_hi_carry", 12'hB80, 32'd1);
    tick();
    check_rd("mcyc_lo_1", 12'hB00, 32'd1);
    csr_op("mcych_5", 12'hB80, OP_WR, 32'd5, 1'b1, 1'b0);
    check_rd("mcych_ld", 12'hB80, 32'd5);
    check_rd("mcyc_lo_held", 12'hB00, 32'd1);

    // full 64-bit wrap
    csr_op("mcyc_lo_max", 12'hB00, OP_WR, 32'hFFFF_FFFF, 1'b1, 1'b0);
    csr_op("mcyc_hi_max", 12'hB80, OP_WR, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check_rd("mcyc_max_lo", 12'hB00, 32'hFFFF_FFFF);
    check_rd("mcyc_max_hi", 12'hB80, 32'hFFFF_FFFF);
    tick();
    check_rd("mcyc_wrap_lo", 12'hB00, 32'd0);
    check_rd("mcyc_wrap_hi", 12'hB80, 32'd0);

    // mcountinhibit freezes both counters
    csr_op("inh_set", 12'h320, OP_WR, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check_rd("inh_mask", 12'h320, 32'h0000_0005);
    csr_op("mcyc_100", 12'hB00, OP_WR, 32'h0000_0100, 1'b1, 1'b0);
    bus.inst_ret = 1'b1;
    repeat (10) tick();
    check_rd("mcyc_frozen", 12'hB00, 32'h0000_0100);
    check_rd("minst_frozen", 12'hB02, 32'd0);
    check_rd("minsth_frozen", 12'hB82, 32'd0);
    csr_op("inh_clr", 12'h320, OP_CLR, 32'h0000_0005, 1'b1, 1'b0);
    check_rd("mcyc_clr_edge", 12'hB00, 32'h0000_0100);
    check_rd("minst_clr_edge", 12'hB02, 32'd0);
    tick();
    check_rd("mcyc_run1", 12'hB00, 32'h0000_0101);
    check_rd("minst_run1", 12'hB02, 32'd1);
    tick();
    check_rd("mcyc_run2", 12'hB00, 32'h0000_0102);
    check_rd("minst_run2", 12'hB02, 32'd2);
    bus.inst_ret = 1'b0;
    tick();
    check_rd("mcyc_run3", 12'hB00, 32'h0000_0103);
    check_rd("minst_idle", 12'hB02, 32'd2);

    // reset asserted with a committing op pending
    bus.csr_addr    = 12'h305;
    bus.csr_write   = 1'b1;
    bus.new_csr_val = 32'h0000_3000;
    bus.valid_write = 1'b1;
    #1 nRST = 1'b0;
    #1;
    check_vec("midrst_mtvec", bus.curr_mtvec, 32'h0000_0200);
    check_vec("midrst_mie", bus.curr_mie, 32'd0);
    check_vec("midrst_mstatus", bus.curr_mstatus, 32'h0000_1800);
    tick();
    check_vec("midrst_edge_mtvec", bus.curr_mtvec, 32'h0000_0200);
    check_vec("midrst_edge_mepc", bus.curr_mepc, 32'd0);
    idle();
    @(negedge CLK) nRST = 1'b1;
    tick();
    check_vec("post_rst_mtvec", bus.curr_mtvec, 32'h0000_0200);
    check_vec("post_rst_mip", bus.curr_mip, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
